// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: FSM states, synchronizer depth, SPI mode.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_slave_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int CPOL        = 0;
    localparam int CPHA        = 0;

endpackage

// File: rtl/module_sincronizador.sv
// Two-FF metastability synchronizer plus one history FF; rise/fall compare the settled stage to history.
module module_sincronizador
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // chain[0..SYNC_STAGES-1] is the synchronizer, chain[SYNC_STAGES] the history bit
    logic [SYNC_STAGES:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {(SYNC_STAGES + 1){RST_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-1:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
    assign fall = ~chain[SYNC_STAGES-1] & chain[SYNC_STAGES];

endmodule

// File: rtl/module_spi_slave.sv
// SPI mode-0 responder, MSB first: oversamples sclk/cs/mosi on clk_i, returns the TX buffer, captures RX bytes.
module module_spi_slave
    import spi_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sclk_i,
    input  logic         cs_i,
    input  logic         bit_rx_i,
    output logic         bit_tx_o,
    output logic         tx_en_o,
    input  logic [N-1:0] tx_data_i,
    input  logic         tx_load_i,
    output logic         tx_ready_o,
    output logic [N-1:0] rx_data_o,
    output logic         rx_valid_o,
    input  logic         rx_ack_i,
    output logic         overrun_o,
    output logic         abort_o
);

    localparam logic          SAMPLE_ON_RISE = (CPOL == CPHA);
    localparam logic          SCLK_IDLE      = 1'(CPOL);
    localparam logic [CW-1:0] LAST           = CW'(N - 1);

    spi_slave_state_t state, next;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    logic [N-1:0]  tx_buf, tx_shift, rx_shift, rx_next;
    logic [CW-1:0] cnt;
    logic          unacked;
    logic          load_evt, sample_evt, shift_evt, exit_evt, consume;

    module_sincronizador #(.RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk_i), .rst(rst_i), .din(sclk_i),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    module_sincronizador #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk_i), .rst(rst_i), .din(cs_i),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    module_sincronizador #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk_i), .rst(rst_i), .din(bit_rx_i),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the mosi level and the sclk/cs edges drive the datapath
    assign unused_sync = mosi_rise ^ mosi_fall ^ sclk_s ^ cs_rise;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Leaving SHIFT keys off the cs level so a cs pulse that lands during LOAD is not lost
    always_comb begin
        next       = state;
        load_evt   = 1'b0;
        sample_evt = 1'b0;
        shift_evt  = 1'b0;
        exit_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) next = LOAD;
            end
            LOAD: begin
                load_evt = 1'b1;
                next     = SHIFT;
            end
            SHIFT: begin
                if (cs_s) begin
                    exit_evt = 1'b1;
                    next     = IDLE;
                end else begin
                    sample_evt = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
                    shift_evt  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
                end
            end
            default: next = IDLE;
        endcase
    end

    assign consume  = load_evt | (shift_evt && (cnt == '0));
    assign rx_next  = {rx_shift[N-2:0], mosi_s};
    assign bit_tx_o = tx_en_o & tx_shift[N-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_en_o    <= 1'b0;
            tx_ready_o <= 1'b1;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
            abort_o    <= 1'b0;
            tx_buf     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            cnt        <= '0;
            unacked    <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            abort_o    <= 1'b0;

            if (load_evt) begin
                tx_en_o <= 1'b1;
                cnt     <= '0;
            end

            if (exit_evt) begin
                tx_en_o  <= 1'b0;
                cnt      <= '0;
                rx_shift <= '0;
                abort_o  <= (cnt != '0);
            end

            if (consume) begin
                tx_shift   <= tx_buf;
                tx_ready_o <= 1'b1;
            end else if (shift_evt) begin
                tx_shift <= tx_shift << 1;
            end

            // A host load in the same cycle as a consume wins the buffer and the ready flag
            if (tx_load_i) begin
                tx_buf     <= tx_data_i;
                tx_ready_o <= 1'b0;
            end

            if (sample_evt) begin
                rx_shift <= rx_next;
                if (cnt == LAST) begin
                    cnt        <= '0;
                    rx_data_o  <= rx_next;
                    rx_valid_o <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (rx_ack_i) begin
                overrun_o <= 1'b0;
            end else if (rx_valid_o && unacked) begin
                overrun_o <= 1'b1;
            end

            if (rx_valid_o) begin
                unacked <= 1'b1;
            end else if (rx_ack_i) begin
                unacked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_module_spi_slave.sv
// Directed bench for module_spi_slave: bit-banged mode-0 master at clk/8 with hand-computed expectations.
module tb_module_spi_slave;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sclk_i = 1'b0;
    logic       cs_i = 1'b1;
    logic       bit_rx_i = 1'b0;
    logic       bit_tx_o;
    logic       tx_en_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_load_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ack_i;
    logic       overrun_o;
    logic       abort_o;

    int n_total = 0;
    int n_pass  = 0;

    logic auto_en    = 1'b1;
    logic manual_ack = 1'b0;
    logic vld_d      = 1'b0;
    logic ack_auto   = 1'b0;
    int   valid_cnt  = 0;
    int   abort_cnt  = 0;
    logic [15:0] rx_hist = 16'h0000;

    always #5 clk_i = ~clk_i;

    module_spi_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .cs_i(cs_i),
        .bit_rx_i(bit_rx_i), .bit_tx_o(bit_tx_o), .tx_en_o(tx_en_o),
        .tx_data_i(tx_data_i), .tx_load_i(tx_load_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i),
        .overrun_o(overrun_o), .abort_o(abort_o)
    );

    // Host side: acknowledge one cycle after each rx_valid when auto_en is set
    assign rx_ack_i = ack_auto | manual_ack;

    always @(negedge clk_i) begin
        vld_d    <= rx_valid_o;
        ack_auto <= auto_en & vld_d;
        if (rx_valid_o) begin
            valid_cnt = valid_cnt + 1;
            rx_hist   = {rx_hist[7:0], rx_data_o};
        end
        if (abort_o) abort_cnt = abort_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data_i = d;
        tx_load_i = 1'b1;
        wait_clk(1);
        tx_load_i = 1'b0;
    endtask

    task automatic cs_begin();
        cs_i = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_end();
        wait_clk(4);
        cs_i = 1'b1;
        wait_clk(8);
    endtask

    // Mode 0: mosi set while sclk low, miso sampled just before the rising edge
    task automatic shift_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bit_rx_i = mo[7-i];
            wait_clk(4);
            mi[7-i] = bit_tx_o;
            sclk_i = 1'b1;
            wait_clk(4);
            sclk_i = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] mi, mi2;
        int v0, a0;
        logic seen_active;

        wait_clk(3);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_tx_en", tx_en_o, 0);
        check("rst_bit_tx", bit_tx_o, 0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_abort", abort_o, 0);
        rst_i = 1'b0;
        wait_clk(3);

        // Single byte
        load_tx(8'hA5);
        check("load_clears_ready", tx_ready_o, 0);
        v0 = valid_cnt;
        cs_begin();
        check("single_tx_en", tx_en_o, 1);
        check("single_ready_after_load", tx_ready_o, 1);
        shift_bits(8'h3C, 8, mi);
        cs_end();
        check("single_miso", mi, 8'hA5);
        check("single_rx_data", rx_data_o, 8'h3C);
        check("single_valid_count", valid_cnt - v0, 1);
        check("single_tx_en_off", tx_en_o, 0);
        check("single_no_overrun", overrun_o, 0);

        // Two bytes under one cs, second TX byte loaded mid-byte 1
        load_tx(8'h11);
        v0 = valid_cnt;
        cs_begin();
        fork
            shift_bits(8'hF0, 8, mi);
            begin
                wait_clk(20);
                load_tx(8'h22);
                check("multi_ready_low_after_load", tx_ready_o, 0);
            end
        join
        shift_bits(8'h0F, 8, mi2);
        cs_end();
        check("multi_miso_b0", mi, 8'h11);
        check("multi_miso_b1", mi2, 8'h22);
        check("multi_valid_count", valid_cnt - v0, 2);
        check("multi_rx_order", rx_hist, 16'hF00F);
        check("multi_ready_end", tx_ready_o, 1);
        check("multi_no_overrun", overrun_o, 0);

        // Overrun: two bytes without acknowledgement
        auto_en = 1'b0;
        cs_begin();
        shift_bits(8'h55, 8, mi);
        shift_bits(8'hAA, 8, mi);
        cs_end();
        check("ovr_set", overrun_o, 1);
        check("ovr_rx_data", rx_data_o, 8'hAA);
        manual_ack = 1'b1;
        wait_clk(1);
        manual_ack = 1'b0;
        wait_clk(1);
        check("ovr_cleared", overrun_o, 0);
        auto_en = 1'b1;

        // Abort after 5 sclk rises
        v0 = valid_cnt;
        a0 = abort_cnt;
        cs_begin();
        shift_bits(8'hFF, 5, mi);
        wait_clk(2);
        cs_i = 1'b1;
        wait_clk(8);
        check("abort_pulses", abort_cnt - a0, 1);
        check("abort_no_valid", valid_cnt - v0, 0);
        check("abort_rx_hold", rx_data_o, 8'hAA);
        cs_begin();
        shift_bits(8'h81, 8, mi);
        cs_end();
        check("after_abort_rx", rx_data_o, 8'h81);
        check("after_abort_valid", valid_cnt - v0, 1);
        check("after_abort_no_abort", abort_cnt - a0, 1);

        // Asynchronous reset mid-frame
        load_tx(8'hC3);
        cs_begin();
        shift_bits(8'h00, 3, mi);
        check("midrst_tx_en_before", tx_en_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_tx_en", tx_en_o, 0);
        check("midrst_bit_tx", bit_tx_o, 0);
        check("midrst_tx_ready", tx_ready_o, 1);
        check("midrst_rx_data", rx_data_o, 8'h00);
        check("midrst_overrun", overrun_o, 0);
        cs_i = 1'b1;
        bit_rx_i = 1'b0;
        wait_clk(3);
        rst_i = 1'b0;
        wait_clk(3);
        load_tx(8'h5A);
        v0 = valid_cnt;
        cs_begin();
        shift_bits(8'h96, 8, mi);
        cs_end();
        check("postrst_miso", mi, 8'h5A);
        check("postrst_rx", rx_data_o, 8'h96);
        check("postrst_valid", valid_cnt - v0, 1);

        // sclk noise with cs high
        v0 = valid_cnt;
        a0 = abort_cnt;
        seen_active = 1'b0;
        bit_rx_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sclk_i = 1'b1;
            wait_clk(4);
            seen_active = seen_active | tx_en_o | bit_tx_o;
            sclk_i = 1'b0;
            wait_clk(4);
            seen_active = seen_active | tx_en_o | bit_tx_o;
        end
        wait_clk(4);
        check("idle_no_valid", valid_cnt - v0, 0);
        check("idle_no_abort", abort_cnt - a0, 0);
        check("idle_quiet_outputs", seen_active, 0);
        check("idle_rx_hold", rx_data_o, 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/module_spi_slave.md
Name: module_spi_slave

Overview:
- SPI responder (slave), mode 0 (CPOL=0, CPHA=0), MSB first, N-bit frames. It is the peripheral-side counterpart of the SPI master interface.
- Oversamples externally driven sclk/cs/mosi on clk_i and returns one byte while capturing one byte per N sclk edges.
- Serves as a loopback and bring-up target for the master on the same FPGA, or as a link to an external master.

Parameters:
- N, 8, bits per frame (shift register and data width).
- CW, $clog2(N), bit counter width.

Ports:
- clk_i  in  1  100 MHz system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- sclk_i  in  1  serial clock from master (async to clk_i). Max frequency is clk_i/8.
- cs_i  in  1  chip select from master, active-low (async).
- bit_rx_i  in  1  MOSI, bits from master.
- bit_tx_o  out  1  MISO, bits to master.
- tx_en_o  out  1  high while selected; drives the external tristate enable for MISO.
- tx_data_i  in  N  byte to return on next frame.
- tx_load_i  in  1  one-cycle strobe; writes tx_data_i into the TX buffer.
- tx_ready_o  out  1  high when the TX buffer has been consumed and can take a new byte.
- rx_data_o  out  N  last complete received byte.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- rx_ack_i  in  1  host has read rx_data_o.
- overrun_o  out  1  sticky flag: new byte completed while previous byte was unacknowledged.
- abort_o  out  1  one-cycle pulse when cs deasserts mid-frame.

Behaviour:
- Reset (async, rst_i=1) sets:
  - bit_tx_o=0, tx_en_o=0, tx_ready_o=1
  - rx_data_o=0, rx_valid_o=0, overrun_o=0, abort_o=0
  - TX buffer=0, shift registers=0, counter=0
  - state=IDLE; synchronizers reset to sclk=0, cs=1, mosi=0.
- Synchronization:
  - sclk, cs and mosi each pass through 2 FFs plus 1 history FF.
  - Edge detects compare stage2 against stage3.
  - All actions are registered one cycle after detection.
  - Pin-to-action latency is 3 clk_i cycles.
- FSM states:
  - IDLE: cs_s=1, tx_en_o=0, bit_tx_o=0. On cs falling edge, go to LOAD.
  - LOAD (1 cycle): tx_shift <= TX buffer; tx_ready_o <= 1; cnt <= 0; tx_en_o <= 1. Go to SHIFT. bit_tx_o = tx_shift[N-1] (MSB) is valid before the first sclk rise.
  - SHIFT:
    - sclk rising edge: rx_shift <= {rx_shift[N-2:0], mosi_s}; cnt <= cnt+1 (wraps at N-1 -> 0).
    - On the rising edge where cnt==N-1: rx_data_o <= {rx_shift[N-2:0], mosi_s}; rx_valid_o pulses next cycle.
    - sclk falling edge with cnt!=0: tx_shift <= tx_shift<<1.
    - sclk falling edge with cnt==0 (byte boundary): tx_shift <= TX buffer; tx_ready_o <= 1. This gives multi-byte frames under one cs.
    - cs rising edge: go to IDLE. If cnt!=0, pulse abort_o, discard the partial rx_shift, and leave rx_data_o unchanged.
- TX buffer rules:
  - tx_load_i loads the buffer and clears tx_ready_o.
  - If tx_load_i coincides with a buffer consume (LOAD or byte boundary):
    - the shift register takes the old buffer value;
    - the buffer takes tx_data_i;
    - tx_ready_o ends low.
  - If nothing is loaded, the buffer value is re-sent (no underrun error).
- RX handshake:
  - An unacked flag sets on rx_valid and clears on rx_ack_i.
  - rx_valid while unacked is set: overrun_o <= 1 and rx_data_o is overwritten with the newest byte.
  - overrun_o clears only on rx_ack_i or reset.
  - rx_ack_i in the same cycle as rx_valid: the new byte counts as unacked and no overrun is raised.
- sclk edges while cs_s=1 are ignored.
- Async reset mid-frame returns to IDLE immediately. The next frame starts with cnt=0.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_slave_state_t
  - localparam SYNC_STAGES=2
  - localparam CPOL=0, CPHA=0
- One sub-module: module_sincronizador (2-FF synchronizer plus history FF, with rising/falling pulse outputs). It is instantiated three times.

Test Plan:
- Single byte: tx_load 0xA5, master sends 0x3C at clk/8. Response: MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C; one rx_valid pulse; tx_ready_o=1 after LOAD.
- Multi-byte under one cs: preload 0x11, then load 0x22 mid-byte 1; master sends 0xF0, 0x0F. Response: MISO returns 0x11, 0x22; rx_valid pulses twice with 0xF0 then 0x0F.
- Overrun: two bytes 0x55, 0xAA with no rx_ack_i. Response: overrun_o=1 after byte 2; rx_data_o=0xAA. rx_ack_i clears overrun_o.
- Abort: cs rises after 5 sclk rises. Response: abort_o pulses once; no rx_valid; rx_data_o holds its prior value; next frame 0x81 is received correctly.
- Reset mid-frame: rst_i asserted after bit 3. Response: all outputs return to reset values asynchronously; tx_ready_o=1; the next full frame is correct.
- Idle noise: sclk toggles 8 times with cs=1. Response: no rx_valid; bit_tx_o=0; tx_en_o=0.
